// File: rtl/mac_result_collector_pkg.sv
// rtl/mac_result_collector_pkg.sv - widths shared between the mac and its result collector
package mac_result_collector_pkg;

    localparam int MAC_DATA_W = 16;
    localparam int MAC_CTRL_W = 8;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mac_sync_fifo.sv
// rtl/mac_sync_fifo.sv - show-ahead synchronous FIFO with separate occupancy count
module mac_sync_fifo
    import mac_result_collector_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // a full FIFO still takes a write when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// rtl/mac_result_collector.sv - captures mac results on IRQ_MAC edges, buffers them for the host
module mac_result_collector
    import mac_result_collector_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int DEPTH  = 8,
    parameter int SUM_W  = 24,
    parameter int THRESH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             MAC_OUT,
    input  logic                          IRQ_MAC,
    input  logic                          CLR,
    output logic [DATA_W-1:0]             RES_DATA,
    output logic                          RES_VALID,
    input  logic                          RES_READY,
    output logic [count_width(DEPTH)-1:0] RES_COUNT,
    output logic [SUM_W-1:0]              RES_SUM,
    output logic                          OVF,
    output logic                          RES_IRQ
);

    localparam int CW = count_width(DEPTH);

    logic          irq_q;
    logic          push_det;
    logic          pop;
    logic          accept;
    logic          full;
    logic          empty;
    logic [CW-1:0] next_count;

    assign push_det  = IRQ_MAC & ~irq_q;
    assign pop       = RES_VALID & RES_READY;
    assign accept    = push_det & (~full | pop);
    assign RES_VALID = ~empty;

    always_comb begin
        next_count = RES_COUNT;
        if (CLR) begin
            next_count = '0;
        end else begin
            next_count = RES_COUNT + CW'(accept) - CW'(pop);
        end
    end

    mac_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (CLR),
        .push  (accept),
        .pop   (pop),
        .wdata (MAC_OUT),
        .rdata (RES_DATA),
        .count (RES_COUNT),
        .full  (full),
        .empty (empty)
    );

    // irq_q resets high so a level already present at reset release is not a capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q   <= 1'b1;
            RES_SUM <= '0;
            OVF     <= 1'b0;
            RES_IRQ <= 1'b0;
        end else begin
            irq_q   <= IRQ_MAC;
            RES_IRQ <= (next_count >= CW'(THRESH));
            if (CLR) begin
                RES_SUM <= '0;
                OVF     <= 1'b0;
            end else begin
                if (accept) begin
                    RES_SUM <= RES_SUM + SUM_W'(MAC_OUT);
                end
                if (push_det && !accept) begin
                    OVF <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_result_collector.sv
// tb/tb_mac_result_collector.sv - directed self-checking bench for mac_result_collector
module tb_mac_result_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] MAC_OUT;
    logic        IRQ_MAC;
    logic        CLR;
    logic [15:0] RES_DATA;
    logic        RES_VALID;
    logic        RES_READY;
    logic [3:0]  RES_COUNT;
    logic [23:0] RES_SUM;
    logic        OVF;
    logic        RES_IRQ;

    int n_vec = 0;
    int n_err = 0;

    mac_result_collector #(
        .DATA_W (16),
        .DEPTH  (8),
        .SUM_W  (24),
        .THRESH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MAC_OUT   (MAC_OUT),
        .IRQ_MAC   (IRQ_MAC),
        .CLR       (CLR),
        .RES_DATA  (RES_DATA),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_COUNT (RES_COUNT),
        .RES_SUM   (RES_SUM),
        .OVF       (OVF),
        .RES_IRQ   (RES_IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] val);
        MAC_OUT = val;
        IRQ_MAC = 1'b1;
        step();
        IRQ_MAC = 1'b0;
        step();
    endtask

    initial begin
        reset     = 1'b0;
        MAC_OUT   = 16'h0;
        IRQ_MAC   = 1'b1;
        CLR       = 1'b0;
        RES_READY = 1'b0;

        // 1: IRQ_MAC high through reset release is not a capture
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        check("t1_valid", 32'(RES_VALID), 32'd0);
        check("t1_count", 32'(RES_COUNT), 32'd0);
        check("t1_sum",   32'(RES_SUM),   32'd0);
        check("t1_ovf",   32'(OVF),       32'd0);
        IRQ_MAC = 1'b0;
        step();

        // 2: two pulses, then drain
        pulse(16'h1234);
        pulse(16'hABCD);
        check("t2_count", 32'(RES_COUNT), 32'd2);
        check("t2_head",  32'(RES_DATA),  32'h1234);
        check("t2_sum",   32'(RES_SUM),   32'h00BE01);
        RES_READY = 1'b1;
        step();
        check("t2_pop1",  32'(RES_DATA),  32'hABCD);
        step();
        check("t2_empty", 32'(RES_VALID), 32'd0);
        RES_READY = 1'b0;

        // 3: held IRQ_MAC yields a single capture of the first-edge value
        MAC_OUT = 16'h5555;
        IRQ_MAC = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            MAC_OUT = 16'h1000 + 16'(i);
            step();
        end
        IRQ_MAC = 1'b0;
        step();
        check("t3_count", 32'(RES_COUNT), 32'd1);
        check("t3_data",  32'(RES_DATA),  32'h5555);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        check("t3_clr",   32'(RES_COUNT), 32'd0);

        // 4: overfill
        for (int i = 1; i <= 9; i++) begin
            pulse(16'hFFFF);
            if (i == 3) check("t4_irq3", 32'(RES_IRQ), 32'd0);
            if (i == 4) check("t4_irq4", 32'(RES_IRQ), 32'd1);
            if (i == 8) check("t4_ovf8", 32'(OVF),     32'd0);
        end
        check("t4_count", 32'(RES_COUNT), 32'd8);
        check("t4_ovf",   32'(OVF),       32'd1);
        check("t4_sum",   32'(RES_SUM),   32'h07FFF8);
        check("t4_irq",   32'(RES_IRQ),   32'd1);

        // 5: capture plus pop while full
        MAC_OUT   = 16'h0042;
        IRQ_MAC   = 1'b1;
        RES_READY = 1'b1;
        step();
        IRQ_MAC   = 1'b0;
        RES_READY = 1'b0;
        step();
        check("t5_count", 32'(RES_COUNT), 32'd8);
        check("t5_ovf",   32'(OVF),       32'd1);
        check("t5_sum",   32'(RES_SUM),   32'h08003A);
        RES_READY = 1'b1;
        repeat (7) step();
        RES_READY = 1'b0;
        check("t5_tail",  32'(RES_DATA),  32'h0042);
        check("t5_cnt1",  32'(RES_COUNT), 32'd1);
        MAC_OUT = 16'h7777;
        IRQ_MAC = 1'b1;
        CLR     = 1'b1;
        step();
        IRQ_MAC = 1'b0;
        CLR     = 1'b0;
        step();
        check("t5_clr_cnt", 32'(RES_COUNT), 32'd0);
        check("t5_clr_sum", 32'(RES_SUM),   32'd0);
        check("t5_clr_ovf", 32'(OVF),       32'd0);
        check("t5_clr_vld", 32'(RES_VALID), 32'd0);

        // 6: async reset mid-stream
        for (int i = 0; i < 5; i++) pulse(16'h0100 + 16'(i));
        check("t6_count", 32'(RES_COUNT), 32'd5);
        check("t6_head",  32'(RES_DATA),  32'h0100);
        check("t6_irq",   32'(RES_IRQ),   32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_cnt",  32'(RES_COUNT), 32'd0);
        check("t6_rst_vld",  32'(RES_VALID), 32'd0);
        check("t6_rst_data", 32'(RES_DATA),  32'd0);
        check("t6_rst_sum",  32'(RES_SUM),   32'd0);
        check("t6_rst_irq",  32'(RES_IRQ),   32'd0);
        step();
        reset = 1'b1;
        step();
        check("t6_after", 32'(RES_VALID), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
